// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-period constants, counter width and the
// transmitter/receiver state encodings.
package uart_pkg;

  localparam int FULL_BIT  = 22274;
  localparam int HALF_BIT  = FULL_BIT / 2;
  localparam int DATA_BITS = 8;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START_BIT,
    TX_DATA_BITS,
    TX_STOP_BIT
  } TxState;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START_BIT,
    RX_DATA_BITS,
    RX_STOP_BIT,
    RX_CLEANUP
  } RxState;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter shared by the UART transmitter and receiver: counts
// 0..FULL_BIT-1 while enabled and flags the last cycle of each bit.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int FULL_BIT = uart_pkg::FULL_BIT
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FULL_BIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign o_terminal = (count_q == LAST);

  // The count restarts on the terminal cycle so it never exceeds FULL_BIT-1.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = o_terminal ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: one byte per valid/ready handshake, sent as start
// bit, eight data bits LSB first and a stop bit, each FULL_BIT cycles long.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int FULL_BIT = uart_pkg::FULL_BIT
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_done
);

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  TxState     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       tx_q, tx_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       timer_clear;
  logic       bit_end;

  assign timer_clear = (state_q == TX_IDLE);

  uart_bit_timer #(
    .FULL_BIT(FULL_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .i_reset   (i_reset),
    .i_clear   (timer_clear),
    .i_enable  (!timer_clear),
    .o_terminal(bit_end)
  );

  // Outputs are computed one cycle ahead so the pins come straight from flops.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (i_valid && ready_q) begin
          shift_d = i_data;
          state_d = TX_START_BIT;
          ready_d = 1'b0;
          tx_d    = 1'b0;
        end
      end
      TX_START_BIT: begin
        tx_d = 1'b0;
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = TX_DATA_BITS;
          tx_d      = shift_q[0];
        end
      end
      TX_DATA_BITS: begin
        tx_d = shift_q[bit_idx_q];
        if (bit_end) begin
          if (bit_idx_q == LAST_IDX) begin
            state_d = TX_STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[bit_idx_q + 3'd1];
          end
        end
      end
      TX_STOP_BIT: begin
        tx_d = 1'b1;
        if (bit_end) begin
          state_d = TX_IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q   <= TX_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign o_tx    = tx_q;
  assign o_ready = ready_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomized scoreboard bench for uart_transmitter: a frame-level line model
// predicts o_tx/o_ready per cycle, and each o_done pops an expected byte.
module tb_uart_transmitter;

  localparam int FB     = 4;
  localparam int FRAME  = 10 * FB;
  localparam int HIST_N = 8192;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_tx;
  logic       o_done;

  always #5 clk = ~clk;

  uart_transmitter #(
    .FULL_BIT(FB)
  ) dut (
    .clk    (clk),
    .i_reset(i_reset),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_tx   (o_tx),
    .o_done (o_done)
  );

  typedef struct {
    logic [7:0] data;
    int         done_cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       exp_item;
  exp_t       got_item;
  int         cyc         = 0;
  int         ready_from  = 0;
  int         frame_start = -1;
  logic [7:0] frame_data  = 8'h00;
  bit         checking    = 1'b0;
  int         compared    = 0;
  int         mismatched  = 0;
  logic       hist [0:HIST_N-1];

  // Line level of bit slot j of an 8N1 frame: 0 = start, 1..8 = data, 9 = stop.
  function automatic logic frame_bit(input logic [7:0] d, input int j);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    return f[j];
  endfunction

  // Recover the byte from the recorded line by sampling each data bit mid-period.
  function automatic logic [7:0] decode_byte(input int end_cyc);
    logic [7:0] b;
    int idx;
    for (int k = 0; k < 8; k++) begin
      idx = end_cyc - FRAME + (k + 1) * FB + FB / 2;
      b[k] = (idx >= 0 && idx < HIST_N) ? hist[idx] : 1'bx;
    end
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic report_fail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s at cycle %0d: got event, expected none", name, cyc);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer a byte and hold i_valid until the transmitter takes it.
  task automatic applyStimulus(input logic [7:0] d);
    int n;
    n       = 0;
    i_data  = d;
    i_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (o_ready === 1'b1) break;
      n++;
      if (n > FRAME + 10) begin
        report_fail("handshake_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_data  = 8'($urandom);
  endtask

  task automatic pulse_reset();
    i_reset = 1'b1;
    wait_cycles(1);
    i_reset = 1'b0;
  endtask

  // Reference model: updates at each edge from the inputs seen during the cycle.
  initial begin
    forever begin
      @(posedge clk);
      if (i_reset === 1'b1) begin
        exp_q.delete();
        frame_start = -1;
        ready_from  = cyc + 1;
        checking    = 1'b1;
      end else if (checking && i_valid === 1'b1 && cyc >= ready_from) begin
        exp_item.data     = i_data;
        exp_item.done_cyc = cyc + 1 + FRAME;
        exp_q.push_back(exp_item);
        frame_start = cyc + 1;
        frame_data  = i_data;
        ready_from  = cyc + 1 + FRAME;
      end
      cyc++;
    end
  end

  // Monitor: per-cycle line checks, plus a scoreboard pop on every o_done.
  initial begin
    logic exp_tx;
    forever begin
      @(negedge clk);
      if (checking) begin
        if (cyc < HIST_N) hist[cyc] = o_tx;
        if (frame_start >= 0 && cyc >= frame_start && cyc < frame_start + FRAME)
          exp_tx = frame_bit(frame_data, (cyc - frame_start) / FB);
        else
          exp_tx = 1'b1;
        checkOutput("tx_line", 32'(o_tx), 32'(exp_tx));
        checkOutput("ready", 32'(o_ready), 32'(cyc >= ready_from));
        if (o_done === 1'b1) begin
          if (exp_q.size() == 0) begin
            report_fail("spurious_done");
          end else begin
            got_item = exp_q.pop_front();
            checkOutput("done_cycle", 32'(cyc), 32'(got_item.done_cyc));
            checkOutput("rx_byte", 32'(decode_byte(cyc)), 32'(got_item.data));
          end
        end else if (o_done !== 1'b0) begin
          checkOutput("done_level", 32'(o_done), 32'(0));
        end
        while (exp_q.size() > 0 && cyc > exp_q[0].done_cyc) begin
          checkOutput("missing_done", 32'(cyc), 32'(exp_q[0].done_cyc));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    compared++;
    mismatched++;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b0;
    wait_cycles(2);

    $display("[TB] single byte A5");
    applyStimulus(8'hA5);
    wait_cycles(FRAME + 3);

    $display("[TB] back-to-back 00 then FF");
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    wait_cycles(FRAME + 3);

    $display("[TB] valid pulse while busy");
    applyStimulus(8'h81);
    wait_cycles(15);
    i_data  = 8'h3C;
    i_valid = 1'b1;
    wait_cycles(1);
    i_valid = 1'b0;
    wait_cycles(FRAME + 3);

    $display("[TB] reset during data bit 3");
    applyStimulus(8'h55);
    wait_cycles(4 * FB + 1);
    pulse_reset();
    wait_cycles(2);
    applyStimulus(8'h12);
    wait_cycles(FRAME + 3);

    $display("[TB] reset and valid together");
    i_reset = 1'b1;
    i_valid = 1'b1;
    i_data  = 8'h99;
    wait_cycles(1);
    i_reset = 1'b0;
    i_valid = 1'b0;
    wait_cycles(3);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(8'($urandom));
      if ($urandom_range(0, 5) == 0) begin
        wait_cycles($urandom_range(1, FRAME));
        pulse_reset();
      end
      wait_cycles($urandom_range(0, 3 * FB));
    end
    wait_cycles(FRAME + 5);

    checkOutput("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial 8N1 UART transmitter: accepts one byte per valid/ready handshake and shifts it out on a single line as start bit, 8 data bits LSB first, and stop bit. Each bit is held for a fixed number of clock cycles. It is the transmit counterpart to the team's UART receiver, shares its bit-period constants, and sits between on-chip byte producers and the off-chip TX pin.

## Interface
- FULL_BIT, 22274: clock cycles per serial bit. Legal range 2..65535.
- clk  input  1  sole clock; all logic is on the rising edge.
- i_reset  input  1  reset, synchronous, active-high.
- i_data  input  8  byte to send; bit 0 is sent first.
- i_valid  input  1  producer offers i_data this cycle.
- o_ready  output  1  transmitter can accept a byte this cycle.
- o_tx  output  1  serial line; idles high.
- o_done  output  1  one-cycle pulse when a frame's stop bit completes.

## Operation
- States: IDLE, START_BIT, DATA_BITS, STOP_BIT.
- Registers:
  - r_state
  - r_shift[7:0]
  - r_bit_idx[2:0]
  - r_cycle_count[15:0]
  - o_tx, o_ready and o_done, all registered with no combinational paths from inputs.
- Reset values: state IDLE, o_tx=1, o_ready=1, o_done=0, counters 0, shift register 0.
- IDLE:
  - o_ready=1 and o_tx=1.
  - On i_valid && o_ready: latch i_data into r_shift, set count=0, go to START_BIT, and set o_ready=0 and o_tx=0 at the same edge.
  - Without i_valid, stay in IDLE.
- START_BIT:
  - o_tx=0. The count increments each cycle.
  - When count == FULL_BIT-1: count=0, bit_idx=0, go to DATA_BITS, and o_tx=r_shift[0].
- DATA_BITS:
  - o_tx=r_shift[bit_idx]. At count == FULL_BIT-1: count=0.
  - If bit_idx==7, go to STOP_BIT with o_tx=1.
  - Otherwise bit_idx+1, and o_tx takes the next bit.
- STOP_BIT:
  - o_tx=1. At count == FULL_BIT-1: count=0, go to IDLE, and set o_ready=1 and o_done=1 for one cycle.
- Counter arithmetic is 16-bit unsigned. The count never exceeds FULL_BIT-1, so no wrap occurs. bit_idx wraps 7→0 only through the state change.
- i_valid and i_data are ignored while o_ready=0. Changes to i_data mid-frame do not affect the frame in flight.
- Reset mid-frame takes effect at the next edge:
  - the frame is aborted immediately;
  - o_tx=1 the following cycle;
  - no o_done is issued.
- If reset and i_valid are asserted in the same cycle, reset wins and the byte is not accepted.

## Timing
- Handshake accepted at edge E: o_tx is low during cycles E+1 .. E+FULL_BIT.
- Data bit k (0..7) is driven during cycles E+1+(k+1)·FULL_BIT .. E+(k+2)·FULL_BIT.
- Stop bit is driven during cycles E+1+9·FULL_BIT .. E+10·FULL_BIT.
- o_ready and o_done are high in cycle E+10·FULL_BIT+1. A new byte can be accepted at that edge.
- Frame length is 10·FULL_BIT cycles. Minimum byte spacing is 10·FULL_BIT+1 cycles, i.e. one idle-high cycle between frames.
- Latency from handshake to the start bit on o_tx is 1 cycle.

## Structure
- Shared package uart_pkg holds:
  - the TxState and RxState enums;
  - FULL_BIT (22274) and HALF_BIT (11137);
  - DATA_BITS=8;
  - the cycle-counter width (16).
- One natural sub-module: uart_bit_timer.
  - It is a 16-bit counter with clear/enable and a terminal-count flag at FULL_BIT-1.
  - The receiver reuses it.
- The shift register and FSM stay in uart_transmitter. Target size is about 150 lines.

## Test plan
- **Single byte:** FULL_BIT=4, send 8'hA5.
  - o_tx is 0 for 4 cycles, then 1,0,1,0,0,1,0,1 with each bit held 4 cycles, then 1 for 4 cycles.
  - o_done pulses at cycle E+41.
- **Back-to-back:** FULL_BIT=4, i_valid held high with 8'h00 then 8'hFF.
  - Second acceptance occurs exactly at E+41.
  - Exactly one idle-high cycle separates the frames.
  - The second frame's data bits are all 1.
- **Ignored input while busy:** i_valid pulsed with 8'h3C mid-frame of 8'h81.
  - Only 8'h81 is transmitted.
  - o_ready stays 0 until the frame ends.
  - No second frame is sent.
- **Reset mid-frame:** assert i_reset during data bit 3 of 8'h55.
  - o_tx=1 and o_ready=1 the cycle after the reset edge.
  - No o_done pulse.
  - The next byte 8'h12 transmits correctly.
- **Loopback:** FULL_BIT=22274, o_tx wired to the UART receiver, bytes 8'h00, 8'h7E, 8'hFF.
  - The receiver reports each byte unchanged.
  - Each frame is 222740 cycles.
- **Reset priority:** i_reset and i_valid asserted in the same cycle.
  - The byte is not accepted, o_tx stays 1, and o_ready=1.
